// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and owner select codes for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_P1   = 3'd1;
    localparam logic [2:0] SEL_P2   = 3'd2;

    // Maps a one-hot grant to the datapath mux select code.
    function automatic logic [2:0] sel_of(input logic [1:0] gnt);
        if (gnt[1]) begin
            return SEL_P2;
        end else if (gnt[0]) begin
            return SEL_P1;
        end
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, completion and memory bus signals of the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req1;
    logic          req2;
    logic          we1;
    logic          we2;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] wdata1;
    logic [DW-1:0] wdata2;
    logic          done1;
    logic          done2;
    logic [DW-1:0] rdata;
    logic          err;
    logic [2:0]    sel;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        input  req1, req2, we1, we2, addr1, addr2, wdata1, wdata2, mem_rdata, mem_ready,
        output done1, done2, rdata, err, sel, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req1, req2, we1, we2, addr1, addr2, wdata1, wdata2, mem_rdata, mem_ready,
        input  done1, done2, rdata, err, sel, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - combinational two-way round-robin pick with one-hot grant
module rr_arb2 (
    input  logic       req1,
    input  logic       req2,
    input  logic       last_p2,
    output logic [1:0] gnt
);
    // On a tie, the port that did not win last time gets the grant.
    always_comb begin
        gnt = 2'b00;
        if (req1 && (!req2 || last_p2)) begin
            gnt = 2'b01;
        end else if (req2) begin
            gnt = 2'b10;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (port 1) and load/store (port 2)
// with round-robin grant, latched request, one-cycle done pulse and access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    mem_port_arbiter_if.master bus
);
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    gnt;
    logic          last_p2;
    logic [2:0]    owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rdata_r;
    logic          err_r;
    logic [CW-1:0] cnt;
    logic          take_grant;
    logic          hit_ready;
    logic          hit_timeout;

    rr_arb2 u_rr (
        .req1    (bus.req1),
        .req2    (bus.req2),
        .last_p2 (last_p2),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // mem_ready is tested before the timeout so a late completion is never flagged.
    always_comb begin
        state_nxt   = state;
        take_grant  = 1'b0;
        hit_ready   = 1'b0;
        hit_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    take_grant = 1'b1;
                    state_nxt  = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    hit_ready = 1'b1;
                    state_nxt = DONE;
                end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
                    hit_timeout = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_p2   <= 1'b1;
            owner     <= SEL_NONE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_r   <= '0;
            err_r     <= 1'b0;
            cnt       <= '0;
        end else begin
            if (take_grant) begin
                owner     <= sel_of(gnt);
                last_p2   <= gnt[1];
                lat_we    <= gnt[1] ? bus.we2    : bus.we1;
                lat_addr  <= gnt[1] ? bus.addr2  : bus.addr1;
                lat_wdata <= gnt[1] ? bus.wdata2 : bus.wdata1;
                cnt       <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
            if (hit_ready) begin
                rdata_r <= bus.mem_rdata;
                err_r   <= 1'b0;
            end else if (hit_timeout) begin
                rdata_r <= '0;
                err_r   <= 1'b1;
            end
        end
    end

    // Outputs decode only state and latched registers; requester inputs never reach them directly.
    assign bus.sel       = (state == IDLE) ? SEL_NONE : owner;
    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && lat_we;
    assign bus.mem_addr  = (state == ACCESS) ? lat_addr  : '0;
    assign bus.mem_wdata = (state == ACCESS) ? lat_wdata : '0;
    assign bus.done1     = (state == DONE) && (owner == SEL_P1);
    assign bus.done2     = (state == DONE) && (owner == SEL_P2);
    assign bus.rdata     = rdata_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdval;
        int          ready_cyc;
        bit          churn;
        logic        exp_err;
        logic [31:0] exp_rdata;
        bit          chk_rdata;
        int          exp_done;
    } vec_t;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        bit          chk_rdata;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req1 = 1'b0;  bus.req2 = 1'b0;
        bus.we1 = 1'b0;   bus.we2 = 1'b0;
        bus.addr1 = '0;   bus.addr2 = '0;
        bus.wdata1 = '0;  bus.wdata2 = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},   32'(bus.sel), 0);
        chk({tag, "_en"},    32'(bus.mem_en), 0);
        chk({tag, "_we"},    32'(bus.mem_we), 0);
        chk({tag, "_addr"},  bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_done1"}, 32'(bus.done1), 0);
        chk({tag, "_done2"}, 32'(bus.done2), 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
        chk({tag, "_err"},   32'(bus.err), 0);
    endtask

    task automatic pop_check();
        sb_t e;
        int  got_port;
        got_port = bus.done1 ? 1 : 2;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: unexpected done on port %0d", got_port);
            return;
        end
        e = sbq.pop_front();
        chk("done_port", 32'(got_port), 32'(e.port));
        chk("done_both", 32'(bus.done1 & bus.done2), 0);
        chk("err", 32'(bus.err), 32'(e.err));
        if (e.chk_rdata) chk("rdata", bus.rdata, e.rdata);
    endtask

    task automatic run_vec(input vec_t v);
        bit done_seen;
        int cyc;
        if (v.port == 1) begin
            bus.req1 = 1'b1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
        end else begin
            bus.req2 = 1'b1; bus.we2 = v.we; bus.addr2 = v.addr; bus.wdata2 = v.wdata;
        end
        bus.mem_rdata = v.rdval;
        bus.mem_ready = 1'b0;
        sbq.push_back('{v.port, v.exp_err, v.exp_rdata, v.chk_rdata});
        done_seen = 1'b0;
        cyc = 0;
        while (!done_seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done1 || bus.done2) begin
                done_seen = 1'b1;
                chk("done_cycle", 32'(cyc), 32'(v.exp_done));
                chk("done_sel", 32'(bus.sel), 32'(v.port));
                chk("done_en", 32'(bus.mem_en), 0);
                pop_check();
            end else begin
                chk("acc_en", 32'(bus.mem_en), 1);
                chk("acc_sel", 32'(bus.sel), 32'(v.port));
                chk("acc_addr", bus.mem_addr, v.addr);
                chk("acc_we", 32'(bus.mem_we), 32'(v.we));
                chk("acc_wdata", bus.mem_wdata, v.wdata);
                if (v.churn) begin
                    if (v.port == 1) begin
                        bus.addr1 = ~v.addr; bus.wdata1 = ~v.wdata; bus.we1 = ~v.we;
                    end else begin
                        bus.addr2 = ~v.addr; bus.wdata2 = ~v.wdata; bus.we2 = ~v.we;
                    end
                end
                bus.mem_ready = (cyc == v.ready_cyc);
            end
        end
        if (!done_seen) begin
            checks++; errors++;
            $display("FAIL done_wait: no done within %0d cycles", cyc);
        end
        idle_inputs();
        @(negedge clk);
        chk("idle_sel", 32'(bus.sel), 0);
        chk("idle_en", 32'(bus.mem_en), 0);
        chk("idle_done", 32'(bus.done1 | bus.done2), 0);
    endtask

    int rr_sel[12] = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};

    initial begin
        //          port we  addr      wdata         rdval         rdy ch  err  exp_rdata     chk done
        vecs[0] = '{1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 1'b0, 32'hDEADBEEF, 1, 2};
        vecs[1] = '{2, 1'b1, 32'h20,  32'h55AA,     32'h0BADF00D, 4, 0, 1'b0, 32'h0,        0, 5};
        vecs[2] = '{1, 1'b0, 32'h44,  32'h0,        32'hFFFF0000, 0, 0, 1'b1, 32'h0,        1, 5};
        vecs[3] = '{1, 1'b0, 32'h48,  32'h0,        32'h12345678, 4, 0, 1'b0, 32'h12345678, 1, 5};
        vecs[4] = '{2, 1'b0, 32'h300, 32'h0,        32'hCAFEF00D, 2, 1, 1'b0, 32'hCAFEF00D, 1, 3};
        vecs[5] = '{1, 1'b1, 32'h104, 32'hA5A5,     32'h00000077, 3, 1, 1'b0, 32'h0,        0, 4};

        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Abort a port 1 access mid-flight; last_grant must fall back to port 2.
        bus.req1 = 1'b1;
        bus.addr1 = 32'h500;
        @(negedge clk);
        chk("abort_en", 32'(bus.mem_en), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(bus.done1 | bus.done2), 0);
        end

        idle_inputs();
        bus.req1 = 1'b1;
        bus.req2 = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h11;
        for (int i = 0; i < 4; i++) begin
            sbq.push_back('{(i % 2 == 0) ? 1 : 2, 1'b0, 32'h11, 1'b1});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("rr_sel_c%0d", i + 1), 32'(bus.sel), 32'(rr_sel[i]));
            chk($sformatf("rr_done1_c%0d", i + 1), 32'(bus.done1), 32'((i % 6) == 1));
            chk($sformatf("rr_done2_c%0d", i + 1), 32'(bus.done2), 32'((i % 6) == 4));
            if (bus.done1 || bus.done2) pop_check();
        end
        idle_inputs();
        chk("sb_drained", 32'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller that shares the single-ported data memory between two requesters: port 1 (instruction fetch) and port 2 (load/store). It arbitrates round-robin, holds the winner's address/write data on the memory bus until `mem_ready`, returns read data with a one-cycle `done` pulse, and aborts hung accesses after a bounded timeout. Its `sel` output drives the 3-bit choice input of the 2:1 datapath select (3'd1 selects port 1, 3'd2 selects port 2), so the downstream mux always follows the current owner.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 16, maximum ACCESS cycles without `mem_ready` before abort; 0 disables the timeout

- `clk` in 1, sole clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `req1` / `req2` in 1, level request from port 1 / port 2
- `we1` / `we2` in 1, write enable of the request
- `addr1` / `addr2` in AW, request address
- `wdata1` / `wdata2` in DW, write data
- `done1` / `done2` out 1, one-cycle completion pulse per port
- `rdata` out DW, read data, valid while a `done` is high
- `err` out 1, high with `done` when the access timed out
- `sel` out 3, owner code: 3'd0 none, 3'd1 port 1, 3'd2 port 2
- `mem_en` out 1, memory access strobe
- `mem_we` out 1, memory write enable
- `mem_addr` out AW, memory address
- `mem_wdata` out DW, memory write data
- `mem_rdata` in DW, memory read data
- `mem_ready` in 1, memory completes the access this cycle

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: `sel`=0, `mem_en`=0. If any `req` is high at the edge, grant one port, latch its `we`/`addr`/`wdata`, set `sel`, and go to ACCESS.
- Arbitration: only one port requesting -> grant it. Both requesting -> grant the port not in `last_grant`. `last_grant` updates on every grant.
- ACCESS: `mem_en`=1 and `mem_we`/`mem_addr`/`mem_wdata` come from the latched request. They stay stable even if the requester changes its inputs.
  - `mem_ready`=1 -> latch `mem_rdata`; `mem_rdata` is latched on writes too, and the value is don't-care. Clear `err` and go to DONE.
  - Timeout with `TIMEOUT`>0: a cycle counter clears on entry to ACCESS. If `mem_ready` is still low in the `TIMEOUT`-th ACCESS cycle, go to DONE with `err`=1 and `rdata`=0.
  - `mem_ready` in that same cycle wins over the timeout, so no error is flagged.
- DONE: pulse `done1` or `done2` (the granted port) for exactly one cycle. `rdata`/`err` are valid and `sel` is held. `mem_en`=0. Then go to IDLE.
- Requester rule: `req` must be low during the IDLE cycle after its `done`; a `req` still high there counts as a new request. `req` must stay high from assertion until `done`. Dropping it earlier has no effect because the access is already latched and completes.
- `rdata` holds its last value until the next DONE.

## Timing
- Reset (asynchronous, any state, including mid-ACCESS): state=IDLE, `last_grant`=port 2 (so port 1 wins the first tie), and counter=0.
  - All outputs go to 0: `sel`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `done1`, `done2`, `rdata`, `err`.
  - An aborted access produces no `done`.
- Zero-wait memory: `req` seen at edge 0 -> ACCESS in cycle 1 -> DONE in cycle 2 -> IDLE in cycle 3. That is a minimum of 3 cycles per transaction, and the next grant can be taken at the edge ending cycle 3.
- N wait cycles (`mem_ready` in ACCESS cycle N+1) -> `done` in cycle N+2.
- Timeout: `done` with `err` in cycle `TIMEOUT`+1 after the grant edge.
- All outputs are registered or decoded purely from state and latched request registers. There is no combinational path from `req*` or `mem_ready` to any output.

## Structure
- Shared package `mem_arb_pkg`: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and select codes SEL_NONE=3'd0, SEL_P1=3'd1, SEL_P2=3'd2. The datapath mux control uses the same select constants.
- One sub-module `rr_arb2`: combinational two-way round-robin pick from `req1`, `req2`, `last_grant`, producing a one-hot grant. The FSM, latches and timeout counter stay in the top.

## Test plan
- Single read: `req1`, `addr1`=0x100, `mem_ready` high in ACCESS cycle 1, `mem_rdata`=0xDEADBEEF.
  - Required: `mem_addr`=0x100 in cycle 1, `done1` in cycle 2, `rdata`=0xDEADBEEF, `sel`=1 in cycles 1-2, `done2`=0.
- Tie and round-robin: after reset, `req1` and `req2` are both held continuously.
  - Required: grants alternate P1, P2, P1, P2, with `sel` 1,2,1,2 and a done every 3 cycles.
- Write with wait states: `req2`, `we2`=1, `addr2`=0x20, `wdata2`=0x55AA, `mem_ready` after 3 wait cycles.
  - Required: `mem_we`=1, `mem_wdata`=0x55AA stable for 4 ACCESS cycles, `done2` in cycle 5, `err`=0.
- Timeout: `TIMEOUT`=4, `mem_ready` never asserted.
  - Required: `done1` with `err`=1 and `rdata`=0 in cycle 5.
  - Companion case: `mem_ready` arrives exactly in ACCESS cycle 4, giving `err`=0.
- Mid-access reset: `rst_n` pulled low in ACCESS cycle 2.
  - Required: all outputs are 0 immediately with no `done`.
  - After release, a tie grants port 1 first.
- Input churn: `addr1` changed during ACCESS.
  - Required: `mem_addr` keeps the latched value until DONE.
